// File: rtl/fanout_fork_fifo.sv
// Buffered eager fork: one upstream stream into a small FIFO, head word broadcast to the
// destinations enabled in dest_en; the head pops once every enabled destination has taken it.
module fanout_fork_fifo #(
   parameter int unsigned NUM_OUT    = 6,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                  CLK,
   input  logic                  ASYNCRESET,
   input  logic                  flush,
   input  logic [NUM_OUT-1:0]    dest_en,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [NUM_OUT-1:0]    out_valid,
   input  logic [NUM_OUT-1:0]    out_ready
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [NUM_OUT-1:0] taken_q, taken_d;

   logic               not_empty;
   logic               push;
   logic               pop;
   logic [NUM_OUT-1:0] fire;
   logic [NUM_OUT-1:0] done;

   assign not_empty = (count_q != '0);
   assign in_ready  = (count_q != FULL_CNT);
   assign push      = in_valid & in_ready;

   assign out_valid = {NUM_OUT{not_empty}} & dest_en & ~taken_q;
   assign fire      = out_valid & out_ready;
   // A destination is complete if disabled, already served, or taking the word this cycle.
   assign done      = ~dest_en | taken_q | out_ready;
   assign pop       = not_empty & (&done);

   assign out_data  = not_empty ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      taken_d  = taken_q;
      if (flush) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         taken_d  = '0;
      end else begin
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            taken_d  = '0;
         end else begin
            taken_d = taken_q | fire;
         end
      end
   end

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         taken_q  <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         taken_q  <= taken_d;
      end
   end

   // Storage is not reset; out_data is masked to zero while empty.
   always_ff @(posedge CLK) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_fanout_fork_fifo.sv
// Directed bench for fanout_fork_fifo: broadcast, staggered accept, backpressure,
// empty mask, flush and asynchronous reset, with hand-computed expectations.
module tb_fanout_fork_fifo;

   logic        CLK = 1'b0;
   logic        ASYNCRESET;
   logic        flush;
   logic [5:0]  dest_en;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic [5:0]  out_valid;
   logic [5:0]  out_ready;

   int n_vec = 0;
   int n_err = 0;

   fanout_fork_fifo #(
      .NUM_OUT   (6),
      .DATA_WIDTH(16),
      .DEPTH     (2)
   ) dut (
      .CLK       (CLK),
      .ASYNCRESET(ASYNCRESET),
      .flush     (flush),
      .dest_en   (dest_en),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic look(input string tag, input int ov, input int rdy, input int dat);
      #1;
      check({tag, ".out_valid"}, 32'(out_valid), ov);
      check({tag, ".in_ready"}, 32'(in_ready), rdy);
      check({tag, ".out_data"}, 32'(out_data), dat);
   endtask

   initial begin
      ASYNCRESET = 1'b1;
      flush      = 1'b0;
      dest_en    = 6'b000000;
      in_data    = 16'h0;
      in_valid   = 1'b0;
      out_ready  = 6'b000000;
      #3;
      look("reset", 0, 1, 0);
      tick();
      ASYNCRESET = 1'b0;

      // Broadcast to destinations 0 and 2 with all readies high.
      dest_en   = 6'b000101;
      out_ready = 6'b111111;
      in_valid  = 1'b1; in_data = 16'h0011;
      look("bc0", 0, 1, 0);
      tick(); in_data = 16'h0022;
      look("bc1", 5, 1, 16'h11);
      tick(); in_data = 16'h0033;
      look("bc2", 5, 1, 16'h22);
      tick(); in_valid = 1'b0;
      look("bc3", 5, 1, 16'h33);
      tick();
      look("bc4", 0, 1, 0);

      // Staggered acceptance: dest 0 takes on cycle 1, dest 1 only on cycle 4.
      dest_en   = 6'b000011;
      out_ready = 6'b000000;
      in_valid  = 1'b1; in_data = 16'h00AA;
      tick(); in_valid = 1'b0;
      out_ready = 6'b000001;
      look("st1", 3, 1, 16'hAA);
      tick(); out_ready = 6'b000000;
      look("st2", 2, 1, 16'hAA);
      tick();
      look("st3", 2, 1, 16'hAA);
      tick(); out_ready = 6'b000010;
      look("st4", 2, 1, 16'hAA);
      tick(); out_ready = 6'b000000;
      look("st5", 0, 1, 0);

      // Full and backpressure with DEPTH=2.
      in_valid = 1'b1; in_data = 16'h0001;
      look("fu0", 0, 1, 0);
      tick(); in_data = 16'h0002;
      look("fu1", 3, 1, 16'h01);
      tick(); in_data = 16'h0003;
      look("fu2", 3, 0, 16'h01);
      tick();
      look("fu3", 3, 0, 16'h01);
      out_ready = 6'b111111;
      look("fu4", 3, 0, 16'h01);
      tick();
      look("fu5", 3, 1, 16'h02);
      tick(); in_valid = 1'b0;
      look("fu6", 3, 1, 16'h03);
      tick();
      look("fu7", 0, 1, 0);

      // Empty mask: every word discarded the cycle after it lands.
      dest_en   = 6'b000000;
      out_ready = 6'b000000;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 16'(16'h00C0 + i);
         look($sformatf("em%0d", i), 0, 1, (i == 0) ? 0 : (16'h00C0 + i - 1));
         tick();
      end
      in_valid = 1'b0;
      look("em5", 0, 1, 16'h00C4);
      tick();
      look("em6", 0, 1, 0);

      // Flush with two entries queued and taken[0] set; concurrent push dropped.
      dest_en  = 6'b000011;
      in_valid = 1'b1; in_data = 16'h0041;
      tick(); in_data = 16'h0042;
      tick(); in_valid = 1'b0;
      out_ready = 6'b000001;
      look("fl0", 3, 0, 16'h41);
      tick(); out_ready = 6'b000000;
      look("fl1", 2, 0, 16'h41);
      flush = 1'b1; in_valid = 1'b1; in_data = 16'h0099;
      tick(); flush = 1'b0; in_valid = 1'b0;
      look("fl2", 0, 1, 0);
      tick();
      look("fl3", 0, 1, 0);
      in_valid = 1'b1; in_data = 16'h0055;
      tick(); in_valid = 1'b0;
      look("fl4", 3, 1, 16'h55);
      out_ready = 6'b111111;
      tick(); out_ready = 6'b000000;
      look("fl5", 0, 1, 0);

      // Asynchronous reset between edges while full.
      in_valid = 1'b1; in_data = 16'h0071;
      tick(); in_data = 16'h0072;
      tick(); in_valid = 1'b0;
      look("ar0", 3, 0, 16'h71);
      #2;
      ASYNCRESET = 1'b1;
      look("ar1", 0, 1, 0);
      #1;
      ASYNCRESET = 1'b0;
      tick();
      look("ar2", 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
